as_uart: RTL and testbench
==========================

# as_uart

Serial transceiver that sits directly upstream of the Wishbone command bridge on the monitor's host link. Converts an asynchronous 8N1 serial line into the bridge's byte-strobe stream (command, address and data bytes). Serialises the bridge's reply bytes back onto the line, applying back-pressure through a busy flag. No buffering: one byte in flight per direction.

## Interface
- BAUD_DIV, 434: clk cycles per bit period (434 gives 115200 baud at 50 MHz); legal range 8..65535.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- serial_in  in  1  asynchronous RX line, idle high.
- serial_out  out  1  TX line, idle high.
- as_data_o  out  8  received byte to bridge; valid while as_dstrb_o is high, held until the next received byte.
- as_dstrb_o  out  1  one-cycle pulse: new byte on as_data_o.
- as_data_i  in  8  byte from bridge to transmit; sampled when as_dstrb_i is high.
- as_dstrb_i  in  1  one-cycle pulse from bridge requesting transmission.
- as_busy_o  out  1  high while the transmitter holds a byte.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- tx_overrun  out  1  one-cycle pulse: as_dstrb_i while as_busy_o high; byte dropped.

## Operation
- Reset values: serial_out=1, as_data_o=8'h00, as_dstrb_o=0, as_busy_o=0, rx_frame_err=0, tx_overrun=0; both FSMs to IDLE, counters cleared.
- Reset mid-frame aborts immediately; TX frame truncated, serial_out high on the cycle after reset is sampled; partial RX byte discarded.
- RX path: serial_in through 2-flop synchroniser; all RX decisions use the synchronised value.
- RX FSM: IDLE -> START on synchronised low; START counts BAUD_DIV/2 (integer division) cycles then re-samples: low -> DATA, high -> IDLE (glitch rejected, no output).
- DATA: 8 samples, one every BAUD_DIV cycles, LSB first, shifted into 8-bit register.
- STOP: sample after BAUD_DIV cycles. High: load as_data_o, pulse as_dstrb_o, go IDLE. Low: pulse rx_frame_err, no strobe, go WAIT_HIGH.
- WAIT_HIGH: stay until synchronised line is high, then IDLE (break condition never produces bytes).
- TX FSM: IDLE accepts as_dstrb_i, latches as_data_i, goes START. START, DATA (8 bits LSB first), STOP each hold serial_out for exactly BAUD_DIV cycles, then IDLE.
- as_busy_o = TX FSM not in IDLE (registered).
- as_dstrb_i while TX not IDLE: byte ignored, tx_overrun pulses same cycle as next-cycle registered output; frame in progress unaffected.
- RX and TX fully independent; simultaneous RX strobe and TX accept allowed.
- Baud counters 16 bits, count down from BAUD_DIV-1 to 0; reload on bit boundary, no wrap drift.

## Timing
- TX: as_dstrb_i high at cycle N -> serial_out low and as_busy_o high from N+1; stop bit ends at N+10*BAUD_DIV; as_busy_o low at N+10*BAUD_DIV+1; next byte accepted that cycle.
- Bridge's own one-cycle strobe gap plus registered busy guarantees no overrun in normal use.
- RX: start edge at line cycle E -> as_dstrb_o at E + 2 (sync) + BAUD_DIV/2 + 9*BAUD_DIV + 1, i.e. mid-stop-bit plus one.
- Sample point tolerance: ±BAUD_DIV/2 cycles accumulated over the frame (about ±4.5% baud mismatch).
- as_dstrb_o, rx_frame_err, tx_overrun: exactly one cycle wide, never coincident for the same frame.

## Configuration
- AS_UART_PARITY_EN defined: 8E1 framing. TX inserts even parity bit (XOR of data) between data and stop; frame = 11 bit periods, busy for 11*BAUD_DIV cycles. RX samples a PARITY state after bit 7; mismatch suppresses as_dstrb_o and pulses rx_frame_err at stop sample (stop-bit check still applied).
- Undefined: 8N1 as above; no parity state exists.

## Test plan
- Reset, BAUD_DIV=8: all outputs at reset values, serial_out held 1 for 100 cycles with serial_in high.
- Drive 8N1 frame 0x02 on serial_in -> single as_dstrb_o pulse with as_data_o=0x02 at predicted cycle; no error pulses.
- Pulse as_dstrb_i with 0xA5 -> serial_out shows 0,1,0,1,0,0,1,0,1,1 each 8 cycles wide; as_busy_o high 80 cycles.
- Second as_dstrb_i 3 cycles after first -> tx_overrun pulse, line waveform unchanged.
- Frame 0x55 with stop bit forced 0 then line held low 40 cycles -> rx_frame_err once, no as_dstrb_o, next valid frame 0x01 received correctly.
- Assert reset mid-TX bit 4 -> serial_out=1 and as_busy_o=0 next cycle; new byte 0x3C afterwards transmitted cleanly. With AS_UART_PARITY_EN, RX 0x03 with parity bit 1 -> rx_frame_err, no strobe.

Source files
------------

// File: rtl/as_uart.sv
// as_uart: serial transceiver on the host link, ahead of the Wishbone command bridge.
// RX turns an asynchronous 8N1 line into one-cycle byte strobes. TX serialises
//   reply bytes and reports back-pressure on as_busy_o. Each direction holds one byte.
// Optional feature macro: AS_UART_PARITY_EN selects 8E1 framing (even parity bit).
// Ports:
//   clk, reset      - system clock; synchronous active-high reset
//   serial_in       - asynchronous RX line, idle high
//   serial_out      - TX line, idle high
//   as_data_o       - last received byte, held until the next one
//   as_dstrb_o      - one-cycle pulse when a new byte lands on as_data_o
//   as_data_i       - byte to transmit, sampled with as_dstrb_i
//   as_dstrb_i      - one-cycle transmit request
//   as_busy_o       - transmitter holds a byte
//   rx_frame_err    - one-cycle pulse: bad stop bit (or bad parity)
//   tx_overrun      - one-cycle pulse: request dropped while busy
module as_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic       serial_out,
    output logic [7:0] as_data_o,
    output logic       as_dstrb_o,
    input  logic [7:0] as_data_i,
    input  logic       as_dstrb_i,
    output logic       as_busy_o,
    output logic       rx_frame_err,
    output logic       tx_overrun
);

    localparam logic [15:0] BIT_M1  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

    // ---------------- RX ----------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef AS_UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t   rx_state;
    logic        rx_meta;
    logic        rx_sync;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_good;

`ifdef AS_UART_PARITY_EN
    logic rx_par_bad;
    assign rx_good = rx_sync && !rx_par_bad;
`else
    assign rx_good = rx_sync;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            as_data_o    <= 8'h00;
            as_dstrb_o   <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef AS_UART_PARITY_EN
            rx_par_bad   <= 1'b0;
`endif
        end else begin
            as_dstrb_o   <= 1'b0;
            rx_frame_err <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= HALF_M1;
                    end
                end
                RX_START: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else if (!rx_sync) begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= BIT_M1;
                        rx_idx   <= 3'd0;
                    end else begin
                        // start bit vanished by mid-bit: treat as a glitch
                        rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= BIT_M1;
                        rx_idx   <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7) begin
`ifdef AS_UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end
                end
`ifdef AS_UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_par_bad <= rx_sync ^ (^rx_shift);
                        rx_cnt     <= BIT_M1;
                        rx_state   <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else if (rx_good) begin
                        as_data_o  <= rx_shift;
                        as_dstrb_o <= 1'b1;
                        rx_state   <= RX_IDLE;
                    end else begin
                        rx_frame_err <= 1'b1;
                        // a low stop bit may be a break: wait for the line to recover
                        rx_state <= rx_sync ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- TX ----------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef AS_UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;
`ifdef AS_UART_PARITY_EN
    logic        tx_par;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            serial_out <= 1'b1;
            as_busy_o  <= 1'b0;
            tx_overrun <= 1'b0;
`ifdef AS_UART_PARITY_EN
            tx_par     <= 1'b0;
`endif
        end else begin
            tx_overrun <= as_dstrb_i && (tx_state != TX_IDLE);
            unique case (tx_state)
                TX_IDLE: begin
                    if (as_dstrb_i) begin
                        tx_shift   <= as_data_i;
`ifdef AS_UART_PARITY_EN
                        tx_par     <= ^as_data_i;
`endif
                        tx_state   <= TX_START;
                        tx_cnt     <= BIT_M1;
                        serial_out <= 1'b0;
                        as_busy_o  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt != 16'd0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else begin
                        serial_out <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                        tx_idx     <= 3'd0;
                        tx_cnt     <= BIT_M1;
                        tx_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt != 16'd0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else begin
                        tx_cnt <= BIT_M1;
                        if (tx_idx == 3'd7) begin
`ifdef AS_UART_PARITY_EN
                            serial_out <= tx_par;
                            tx_state   <= TX_PARITY;
`else
                            serial_out <= 1'b1;
                            tx_state   <= TX_STOP;
`endif
                        end else begin
                            serial_out <= tx_shift[0];
                            tx_shift   <= tx_shift >> 1;
                            tx_idx     <= tx_idx + 3'd1;
                        end
                    end
                end
`ifdef AS_UART_PARITY_EN
                TX_PARITY: begin
                    if (tx_cnt != 16'd0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else begin
                        serial_out <= 1'b1;
                        tx_cnt     <= BIT_M1;
                        tx_state   <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_cnt != 16'd0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else begin
                        tx_state  <= TX_IDLE;
                        as_busy_o <= 1'b0;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_as_uart.sv
// tb_as_uart: directed test of as_uart at BAUD_DIV=8.
// Covers reset, RX timing, TX waveform, overrun, framing error, glitch and reset mid-TX.
module tb_as_uart;

    localparam int B = 8;
`ifdef AS_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int RXLAT = B / 2 + (NBITS - 1) * B + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       serial_out;
    logic [7:0] as_data_o;
    logic       as_dstrb_o;
    logic [7:0] as_data_i = 8'h00;
    logic       as_dstrb_i = 1'b0;
    logic       as_busy_o;
    logic       rx_frame_err;
    logic       tx_overrun;

    as_uart #(.BAUD_DIV(B)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_out   (serial_out),
        .as_data_o    (as_data_o),
        .as_dstrb_o   (as_dstrb_o),
        .as_data_i    (as_data_i),
        .as_dstrb_i   (as_dstrb_i),
        .as_busy_o    (as_busy_o),
        .rx_frame_err (rx_frame_err),
        .tx_overrun   (tx_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_strb = 0;
    int n_err = 0;
    int n_ovr = 0;
    int strb_cyc = 0;
    logic [7:0] strb_data = 8'h00;
    int rx_e = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (as_dstrb_o) begin
            n_strb++;
            strb_cyc = cyc;
            strb_data = as_data_o;
        end
        if (rx_frame_err) n_err++;
        if (tx_overrun) n_ovr++;
    endtask

    task automatic clr();
        n_strb = 0;
        n_err = 0;
        n_ovr = 0;
    endtask

    task automatic hold(input logic v, input int n);
        serial_in = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    // drives one frame; parity argument is the line level in the parity slot
    task automatic rx_send(input logic [7:0] d, input logic par, input logic stop);
        rx_e = cyc + 1;
        hold(1'b0, B);
        for (int k = 0; k < 8; k++) hold(d[k], B);
`ifdef AS_UART_PARITY_EN
        hold(par, B);
`else
        if (par) hold(1'b1, 0);
`endif
        hold(stop, B);
    endtask

    task automatic tx_send(input logic [7:0] d, input logic ovr);
        logic [10:0] fr;
        int wave_bad;
        int busy_n;
`ifdef AS_UART_PARITY_EN
        fr = {1'b1, ^d, d, 1'b0};
`else
        fr = {1'b0, 1'b1, d, 1'b0};
`endif
        wave_bad = 0;
        busy_n = 0;
        clr();
        as_data_i = d;
        as_dstrb_i = 1'b1;
        tick();
        as_dstrb_i = 1'b0;
        for (int i = 0; i < NBITS * B; i++) begin
            if (serial_out !== fr[i / B]) wave_bad++;
            if (as_busy_o === 1'b1) busy_n++;
            as_dstrb_i = ovr && (i == 2);
            as_data_i = as_dstrb_i ? 8'hFF : d;
            tick();
        end
        as_dstrb_i = 1'b0;
        check("tx_wave", wave_bad, 0);
        check("tx_busy_len", busy_n, NBITS * B);
        check("tx_busy_end", as_busy_o, 1'b0);
        check("tx_line_end", serial_out, 1'b1);
        check("tx_ovr", n_ovr, ovr ? 1 : 0);
    endtask

    initial begin
        int lowcnt;

        tick();
        tick();
        check("rst_out", serial_out, 1'b1);
        check("rst_data", as_data_o, 8'h00);
        check("rst_strb", as_dstrb_o, 1'b0);
        check("rst_busy", as_busy_o, 1'b0);
        check("rst_err", rx_frame_err, 1'b0);
        check("rst_ovr", tx_overrun, 1'b0);
        reset = 1'b0;
        clr();
        lowcnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (serial_out !== 1'b1) lowcnt++;
        end
        check("idle_line", lowcnt, 0);
        check("idle_pulses", n_strb + n_err + n_ovr, 0);

        // RX 0x02
        clr();
        rx_send(8'h02, 1'b1, 1'b1);
        hold(1'b1, 2 * B);
        check("rx02_n", n_strb, 1);
        check("rx02_data", strb_data, 8'h02);
        check("rx02_lat", strb_cyc - rx_e, RXLAT);
        check("rx02_err", n_err, 0);
        check("rx02_hold", as_data_o, 8'h02);

        // TX 0xA5 with a second request 3 cycles in
        tx_send(8'hA5, 1'b1);

        // framing error followed by a break, then recovery
        clr();
        rx_send(8'h55, 1'b0, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 2 * B);
        check("fe_err", n_err, 1);
        check("fe_strb", n_strb, 0);
        clr();
        rx_send(8'h01, 1'b1, 1'b1);
        hold(1'b1, 2 * B);
        check("rx01_n", n_strb, 1);
        check("rx01_data", strb_data, 8'h01);
        check("rx01_lat", strb_cyc - rx_e, RXLAT);
        check("rx01_err", n_err, 0);

        // short low glitch must be rejected
        clr();
        hold(1'b0, 2);
        hold(1'b1, 3 * B);
        check("glitch", n_strb + n_err, 0);

        // reset during data bit 4
        clr();
        as_data_i = 8'hC3;
        as_dstrb_i = 1'b1;
        tick();
        as_dstrb_i = 1'b0;
        for (int i = 0; i < 5 * B + 3; i++) tick();
        check("mid_busy", as_busy_o, 1'b1);
        reset = 1'b1;
        tick();
        check("cut_line", serial_out, 1'b1);
        check("cut_busy", as_busy_o, 1'b0);
        reset = 1'b0;
        tick();
        tx_send(8'h3C, 1'b0);

`ifdef AS_UART_PARITY_EN
        clr();
        rx_send(8'h03, 1'b1, 1'b1);
        hold(1'b1, 2 * B);
        check("par_err", n_err, 1);
        check("par_strb", n_strb, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
